// File: rtl/sstv_ram_writer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sstv_ram_writer : quantises the SSTV pixel stream into the 2-bit frame RAM
// Revision        : 1.0
// ----------------------------------------------------------------------------
module sstv_ram_writer #(
    parameter int COLS   = 160,
    parameter int ROWS   = 120,
    parameter int ADDR_W = 15,
    parameter int LUM_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_req,
    input  logic              frame_start,
    input  logic              line_sync,
    input  logic              pix_valid,
    input  logic [LUM_W-1:0]  pix_lum,
    output logic [ADDR_W-1:0] sstv_ram_addr,
    output logic [1:0]        sstv_ram_data,
    output logic              sstv_ram_we,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun,
    output logic [6:0]        cur_row
);

    localparam int                COL_W       = $clog2(COLS + 1);
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] c_COLS_A    = ADDR_W'(COLS);
    localparam logic [COL_W-1:0]  c_COLS_C    = COL_W'(COLS);
    localparam logic [6:0]        c_LAST_ROW  = 7'(ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_LINE = 2'd1,
        S_PIXELS    = 2'd2,
        S_CLEAR     = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [6:0]          row_q, row_d;
    logic [ADDR_W-1:0]   row_base_q, row_base_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          data_q, data_d;
    logic                we_q, we_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                overrun_q, overrun_d;

    // Only the top two luminance bits reach the RAM.
    logic unused_lum;
    assign unused_lum = ^pix_lum[LUM_W-3:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            clr_cnt_q  <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            clr_cnt_q  <= clr_cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            we_q       <= we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        clr_cnt_d  = clr_cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        we_d       = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        overrun_d  = overrun_q;

        if (state_q == S_CLEAR) begin
            // Inputs are deliberately ignored until the sweep completes.
            we_d   = 1'b1;
            busy_d = 1'b1;
            addr_d = clr_cnt_q;
            data_d = 2'b00;
            if (clr_cnt_q == c_LAST_ADDR) begin
                state_d    = S_IDLE;
                row_d      = '0;
                col_d      = '0;
                row_base_d = '0;
                overrun_d  = 1'b0;
            end else begin
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            end
        end else if (clear_req) begin
            state_d   = S_CLEAR;
            clr_cnt_d = '0;
            overrun_d = 1'b0;
        end else if (frame_start) begin
            state_d    = S_WAIT_LINE;
            row_d      = '0;
            col_d      = '0;
            row_base_d = '0;
            overrun_d  = 1'b0;
        end else if (state_q == S_WAIT_LINE) begin
            if (line_sync) begin
                state_d = S_PIXELS;
                col_d   = '0;
            end
        end else if (state_q == S_PIXELS) begin
            if (line_sync) begin
                if (row_q == c_LAST_ROW) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    row_d      = row_q + 7'd1;
                    row_base_d = row_base_q + c_COLS_A;
                    col_d      = '0;
                end
            end else if (pix_valid) begin
                if (col_q < c_COLS_C) begin
                    we_d   = 1'b1;
                    addr_d = row_base_q + ADDR_W'(col_q);
                    data_d = pix_lum[LUM_W-1:LUM_W-2];
                    col_d  = col_q + COL_W'(1);
                end else begin
                    overrun_d = 1'b1;
                end
            end
        end
    end

    assign sstv_ram_addr = addr_q;
    assign sstv_ram_data = data_q;
    assign sstv_ram_we   = we_q;
    assign busy          = busy_q;
    assign frame_done    = done_q;
    assign overrun       = overrun_q;
    assign cur_row       = row_q;

endmodule
`default_nettype wire

// File: tb/tb_sstv_ram_writer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sstv_ram_writer : directed/random bench against a frame-level model
// Revision           : 1.0
// ----------------------------------------------------------------------------
module tb_sstv_ram_writer;

    localparam int COLS   = 160;
    localparam int ROWS   = 120;
    localparam int ADDR_W = 15;
    localparam int LUM_W  = 8;

    localparam int c_M_IDLE = 0;
    localparam int c_M_WAIT = 1;
    localparam int c_M_PIX  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clear_req = 1'b0;
    logic              frame_start = 1'b0;
    logic              line_sync = 1'b0;
    logic              pix_valid = 1'b0;
    logic [LUM_W-1:0]  pix_lum = '0;
    logic [ADDR_W-1:0] sstv_ram_addr;
    logic [1:0]        sstv_ram_data;
    logic              sstv_ram_we;
    logic              busy;
    logic              frame_done;
    logic              overrun;
    logic [6:0]        cur_row;

    int n_assert = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    int fd_cnt   = 0;
    int m_st     = c_M_IDLE;
    int m_row    = 0;
    int m_col    = 0;
    int m_ovr    = 0;
    int base;
    int fbase;

    always #5 clk = ~clk;

    sstv_ram_writer #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W),
        .LUM_W  (LUM_W)
    ) dut (
        .clk           (clk),
        .reset         (rst_n),
        .clear_req     (clear_req),
        .frame_start   (frame_start),
        .line_sync     (line_sync),
        .pix_valid     (pix_valid),
        .pix_lum       (pix_lum),
        .sstv_ram_addr (sstv_ram_addr),
        .sstv_ram_data (sstv_ram_data),
        .sstv_ram_we   (sstv_ram_we),
        .busy          (busy),
        .frame_done    (frame_done),
        .overrun       (overrun),
        .cur_row       (cur_row)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (sstv_ram_we === 1'b1) wr_cnt++;
        if (frame_done === 1'b1) fd_cnt++;
        chk("we_with_done", {31'd0, sstv_ram_we & frame_done}, 32'd0);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pixel(input int lum);
        pix_valid = 1'b1;
        pix_lum   = LUM_W'(lum);
        tick();
        pix_valid = 1'b0;
        if (m_st == c_M_PIX && m_col < COLS) begin
            chk("pix_we",   sstv_ram_we,   1);
            chk("pix_addr", sstv_ram_addr, m_row * COLS + m_col);
            chk("pix_data", sstv_ram_data, lum / 64);
            m_col++;
        end else begin
            chk("pix_no_we", sstv_ram_we, 0);
            if (m_st == c_M_PIX) m_ovr = 1;
        end
        chk("pix_overrun", overrun, m_ovr);
    endtask

    task automatic sync();
        int exp_done;
        exp_done  = 0;
        line_sync = 1'b1;
        tick();
        line_sync = 1'b0;
        if (m_st == c_M_WAIT) begin
            m_st  = c_M_PIX;
            m_col = 0;
        end else if (m_st == c_M_PIX) begin
            if (m_row == ROWS - 1) begin
                exp_done = 1;
                m_st     = c_M_IDLE;
            end else begin
                m_row++;
                m_col = 0;
            end
        end
        chk("sync_done",    frame_done,  exp_done);
        chk("sync_no_we",   sstv_ram_we, 0);
        chk("sync_cur_row", cur_row,     m_row);
    endtask

    task automatic fstart();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        m_st  = c_M_WAIT;
        m_row = 0;
        m_col = 0;
        m_ovr = 0;
        chk("fs_overrun", overrun,     0);
        chk("fs_cur_row", cur_row,     0);
        chk("fs_no_we",   sstv_ram_we, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk("rst_we",   sstv_ram_we,   0);
        chk("rst_busy", busy,          0);
        chk("rst_done", frame_done,    0);
        chk("rst_ovr",  overrun,       0);
        chk("rst_row",  cur_row,       0);
        chk("rst_addr", sstv_ram_addr, 0);
        chk("rst_data", sstv_ram_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Three known luminances land at addresses 0..2.
        fstart();
        sync();
        base = wr_cnt;
        pixel(8'h00);
        chk("t1_d0", sstv_ram_data, 0);
        pixel(8'h7F);
        chk("t1_d1", sstv_ram_data, 1);
        pixel(8'hC0);
        chk("t1_d2", sstv_ram_data, 3);
        chk("t1_a2", sstv_ram_addr, 2);
        tick();
        chk("t1_gap_we", sstv_ram_we, 0);
        chk("t1_count",  wr_cnt - base, 3);

        // Full frame of random pixels.
        fstart();
        base  = wr_cnt;
        fbase = fd_cnt;
        for (int l = 0; l < ROWS; l++) begin
            sync();
            for (int c = 0; c < COLS; c++) pixel($urandom_range(0, 255));
        end
        chk("ff_last_addr", sstv_ram_addr, COLS * ROWS - 1);
        sync();
        tick();
        chk("ff_done_low", frame_done,     0);
        chk("ff_writes",   wr_cnt - base,  COLS * ROWS);
        chk("ff_done_cnt", fd_cnt - fbase, 1);
        chk("ff_cur_row",  cur_row,        ROWS - 1);
        pixel($urandom_range(0, 255));
        sync();
        pixel($urandom_range(0, 255));

        // Overlong line 5 sets a sticky overrun.
        fstart();
        sync();
        for (int l = 0; l < 5; l++) begin
            for (int k = 0; k < 3; k++) pixel($urandom_range(0, 255));
            sync();
        end
        chk("ov_row5", cur_row, 5);
        base = wr_cnt;
        for (int k = 0; k < COLS + 2; k++) begin
            pixel($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) tick();
        end
        chk("ov_writes", wr_cnt - base, COLS);
        chk("ov_set",    overrun,       1);
        sync();
        pixel($urandom_range(0, 255));
        chk("ov_addr960", sstv_ram_addr, 960);
        chk("ov_sticky",  overrun,       1);
        fstart();

        // Mid-frame clear at row 10, combined with frame_start and pixel.
        sync();
        for (int l = 0; l < 10; l++) sync();
        pixel($urandom_range(0, 255));
        chk("cl_row10", cur_row, 10);
        clear_req   = 1'b1;
        frame_start = 1'b1;
        pix_valid   = 1'b1;
        pix_lum     = LUM_W'($urandom_range(0, 255));
        tick();
        clear_req   = 1'b0;
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        chk("cl_no_pix_write", sstv_ram_we, 0);
        for (int i = 0; i < COLS * ROWS; i++) begin
            if (i == 100) frame_start = 1'b1;
            if (i == 200) clear_req = 1'b1;
            tick();
            frame_start = 1'b0;
            clear_req   = 1'b0;
            chk("cl_busy", busy,          1);
            chk("cl_we",   sstv_ram_we,   1);
            chk("cl_addr", sstv_ram_addr, i);
            chk("cl_data", sstv_ram_data, 0);
        end
        tick();
        m_st  = c_M_IDLE;
        m_row = 0;
        m_col = 0;
        m_ovr = 0;
        chk("cl_busy_low", busy,        0);
        chk("cl_we_low",   sstv_ram_we, 0);
        chk("cl_cur_row",  cur_row,     0);
        chk("cl_ovr",      overrun,     0);
        pixel($urandom_range(0, 255));
        sync();
        pixel($urandom_range(0, 255));

        // line_sync outranks a same-cycle pixel.
        fstart();
        sync();
        pixel($urandom_range(0, 255));
        line_sync = 1'b1;
        pix_valid = 1'b1;
        pix_lum   = LUM_W'($urandom_range(0, 255));
        tick();
        line_sync = 1'b0;
        pix_valid = 1'b0;
        chk("ls_no_we",   sstv_ram_we, 0);
        chk("ls_cur_row", cur_row,     1);
        m_row = 1;
        m_col = 0;
        pixel($urandom_range(0, 255));
        chk("ls_addr160", sstv_ram_addr, COLS);

        // Asynchronous reset in the middle of a clear.
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (501) tick();
        chk("ar_addr500", sstv_ram_addr, 500);
        chk("ar_we_pre",  sstv_ram_we,   1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_we",   sstv_ram_we,   0);
        chk("ar_busy", busy,          0);
        chk("ar_addr", sstv_ram_addr, 0);
        m_st  = c_M_IDLE;
        m_row = 0;
        m_col = 0;
        m_ovr = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        base = wr_cnt;
        for (int i = 0; i < 20; i++) begin
            pix_valid = 1'b1;
            pix_lum   = LUM_W'($urandom_range(0, 255));
            line_sync = (i % 5 == 0);
            tick();
            chk("ar_no_we", sstv_ram_we, 0);
        end
        pix_valid = 1'b0;
        line_sync = 1'b0;
        chk("ar_writes",  wr_cnt - base, 0);
        chk("ar_cur_row", cur_row,       0);
        chk("ar_busy_lo", busy,          0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sstv_ram_writer.md
Name: sstv_ram_writer

Overview:
Write side of the SSTV output RAM. Takes the demodulator's per-pixel luminance stream and its frame/line sync strobes, quantises each pixel to 2 bits, and writes it to the 160x120 RAM (address = row*160 + col) that the VGA translator scans out. It also provides a full-RAM clear sequence, so a new reception starts on a blank image.

Parameters:
COLS, 160, pixels per line
ROWS, 120, lines per frame
ADDR_W, 15, RAM address width; must satisfy COLS*ROWS <= 2**ADDR_W
LUM_W, 8, input luminance width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
clear_req  in  1  one-cycle pulse; zero the entire RAM
frame_start  in  1  one-cycle pulse; VIS/frame header detected
line_sync  in  1  one-cycle pulse; horizontal sync detected
pix_valid  in  1  one-cycle pulse; pix_lum holds a new pixel
pix_lum  in  LUM_W  pixel luminance, unsigned
sstv_ram_addr  out  ADDR_W  RAM write address
sstv_ram_data  out  2  RAM write data
sstv_ram_we  out  1  RAM write enable, one write per asserted cycle
busy  out  1  high during CLEAR
frame_done  out  1  one-cycle pulse when row ROWS-1 completes
overrun  out  1  sticky; pixel received with col == COLS; cleared by frame_start or clear_req
cur_row  out  7  row currently being written

Behaviour:
- Reset (reset low, asynchronous): state IDLE. All outputs 0. Internal col, row and row_base = 0. Reset mid-clear or mid-frame abandons the operation; no further writes occur.
- All outputs are registered. A RAM write appears one cycle after the accepted pix_valid, or on the cycle after each clear step.
- Quantisation: sstv_ram_data = pix_lum[LUM_W-1:LUM_W-2] (top two bits). In CLEAR, data = 2'b00.
- Address generation: no multiplier. row_base += COLS on each row advance; addr = row_base + col. Widths are ADDR_W, unsigned.
- Event priority in the same cycle: clear_req > frame_start > line_sync > pix_valid.
- States:
  - IDLE: discard pixels and syncs. clear_req -> CLEAR. frame_start -> WAIT_LINE with row = 0, row_base = 0, overrun = 0.
  - WAIT_LINE: ignore pix_valid. line_sync -> PIXELS with col = 0.
  - PIXELS:
    - pix_valid with col < COLS: write (addr = row_base+col, lum quantised), then col++.
    - pix_valid with col == COLS: no write; set overrun.
    - line_sync ends the line. Any unwritten columns keep their old contents. If row == ROWS-1: pulse frame_done and go to IDLE. Otherwise row++, row_base += COLS, col = 0, stay in PIXELS (the sync starts the next line).
    - frame_start restarts at row 0 and goes to WAIT_LINE.
  - CLEAR: busy = 1. Writes 0 to addr 0..COLS*ROWS-1, one address per cycle, sstv_ram_we high every cycle. That is 19200 writes at the defaults. After the last write: busy falls next cycle, state IDLE, row = col = 0, overrun = 0. All inputs, including frame_start and a repeat clear_req, are ignored while busy.
- clear_req in WAIT_LINE/PIXELS aborts the frame and enters CLEAR; frame_done is not pulsed.
- cur_row reflects the row register; it is 0 in IDLE after reset or clear, and holds the last row value after frame_done.
- frame_done is never asserted together with sstv_ram_we.

Test Plan:
- Reset, then frame_start, line_sync, 3 pixels lum 0x00/0x7F/0xC0 -> writes at addr 0,1,2 with data 0,1,3; we high exactly 3 cycles, each one cycle after its pix_valid.
- Full frame: 120 line_syncs, each followed by 160 pixels -> 19200 writes; last write addr 19199; frame_done pulses once on the 120th line's closing sync (121st line_sync); state IDLE.
- Line 5 with 162 pixels -> 160 writes for addr 800..959; overrun=1 and stays high; next frame_start clears it.
- clear_req mid-frame at row 10 -> busy high 19200 cycles, addresses 0..19199 with data 0; frame_start pulsed during busy ignored; busy low afterwards and cur_row=0.
- Same cycle clear_req+frame_start+pix_valid in PIXELS -> CLEAR entered, no pixel write. Same cycle line_sync+pix_valid -> row advances, no write.
- reset asserted asynchronously mid-clear at addr 500 -> we, busy and addr drop to 0 immediately; no writes after reset release until a new clear_req or frame_start.
